uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Queued words are serialised LSB-first,
// with optional parity and one or two stop bits, and leave back-to-back.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_din,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_ovf,
  output logic                 TX
);

  localparam int unsigned CW = $clog2(OVERSAMPLE * 2);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BitLast  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] StopLast = CW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [AW:0]            count, count_d;
  logic [DATA_BITS-1:0]   head;
  logic                   wr_ok, pop;

  assign head  = mem[rptr];
  assign wr_ok = tx_wr & ~tx_full;

  // The FSM pops either from idle or on the final cycle of the stop interval.
  always_comb begin
    pop = ~tx_empty & ((state == StIdle) | ((state == StStop) & (cnt == StopLast)));
  end

  always_comb begin
    count_d = count;
    if (wr_ok && !pop) begin
      count_d = count + 1'b1;
    end else if (!wr_ok && pop) begin
      count_d = count - 1'b1;
    end
  end

  always_ff @(posedge bclk) begin
    if (wr_ok) begin
      mem[wptr] <= tx_din;
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      tx_ovf   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count    <= count_d;
      tx_full  <= (count_d == (AW+1)'(FIFO_DEPTH));
      tx_empty <= (count_d == '0);
      tx_ovf   <= tx_wr & tx_full;
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      TX      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        StIdle: begin
          TX <= 1'b1;
        end
        StStart: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            TX    <= shift[0];
            state <= StData;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (bit_idx == DataLast) begin
              if (PARITY != 0) begin
                TX    <= par_bit;
                state <= StParity;
              end else begin
                TX    <= 1'b1;
                state <= StStop;
              end
            end else begin
              shift   <= shift >> 1;
              TX      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StParity: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            TX    <= 1'b1;
            state <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == StopLast) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            if (tx_empty) begin
              TX      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase

      // Loading a new word overrides whatever the current state decided.
      if (pop) begin
        shift   <= head;
        par_bit <= (PARITY == 2) ? ^head : ~^head;
        TX      <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
        tx_busy <= 1'b1;
        state   <= StStart;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets, each checked every cycle against a
// frame-level model built from a word queue and a per-frame bit vector.
module tb_uart_tx_fifo;

  logic bclk = 1'b0;
  always #5 bclk = ~bclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int DB    = (g == 3) ? 9 : (g == 2) ? 7 : 8;
    localparam int OS    = (g == 3) ? 5 : 16;
    localparam int PAR   = (g == 1) ? 2 : (g == 3) ? 1 : 0;
    localparam int SB    = (g == 2) ? 2 : 1;
    localparam int DEPTH = (g == 3) ? 2 : 4;
    localparam int NB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int F     = OS * NB;
    localparam int PAT   = (g == 0) ? 'h55 : (g == 2) ? 'h7F : 'h07;

    logic          rst, wr;
    logic [DB-1:0] din;
    logic          full, empty, busy, done, ovf, tx;

    uart_tx_fifo #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .FIFO_DEPTH(DEPTH)
    ) dut (
      .bclk    (bclk),
      .rst     (rst),
      .tx_din  (din),
      .tx_wr   (wr),
      .tx_full (full),
      .tx_empty(empty),
      .tx_busy (busy),
      .tx_done (done),
      .tx_ovf  (ovf),
      .TX      (tx)
    );

    // Reference model state
    logic [DB-1:0] q[$];
    bit            active;
    int            t;
    logic [15:0]   fbits, sh;
    bit            m_done, m_ovf, full_pre;
    logic          wr_s;
    logic [DB-1:0] din_s;
    bit            fin;

    int cyc_cnt, n_ovf, n_done;
    bit seen, gap, full_seen;

    // Frame bit vector: bit 0 is the start bit, then data LSB-first, parity, stop ones.
    function automatic logic [15:0] frame_of(input logic [DB-1:0] w);
      logic [15:0] b;
      logic        p;
      p = (PAR == 2) ? ^w : ~^w;
      b = (16'hFFFF << (DB + 1)) | (16'(w) << 1);
      if (PAR != 0) begin
        b = b & ~(16'h1 << (DB + 1));
        b = b | (16'(p) << (DB + 1));
      end
      return b;
    endfunction

    initial begin : model
      active = 0; t = 0; fbits = '1; m_done = 0; m_ovf = 0;
      @(negedge bclk);
      forever begin
        @(posedge bclk or posedge rst);
        if (rst) begin
          q.delete();
          active = 0; t = 0; m_done = 0; m_ovf = 0;
        end else begin
          wr_s     = wr;
          din_s    = din;
          full_pre = (q.size() == DEPTH);
          m_ovf    = wr_s && full_pre;
          m_done   = 0;
          if (active) begin
            t++;
            if (t == F) begin
              m_done = 1;
              active = 0;
            end
          end
          if (!active && q.size() > 0) begin
            fbits  = frame_of(q.pop_front());
            active = 1;
            t      = 0;
          end
          if (wr_s && !full_pre) q.push_back(din_s);
        end
        #1;
        sh = fbits >> (t / OS);
        check($sformatf("c%0d.tx", g), 32'(tx), 32'(active ? sh[0] : 1'b1));
        check($sformatf("c%0d.busy", g), 32'(busy), 32'(active));
        check($sformatf("c%0d.done", g), 32'(done), 32'(m_done));
        check($sformatf("c%0d.ovf", g), 32'(ovf), 32'(m_ovf));
        check($sformatf("c%0d.empty", g), 32'(empty), 32'(q.size() == 0));
        check($sformatf("c%0d.full", g), 32'(full), 32'(q.size() == DEPTH));
      end
    end

    initial begin : drive
      fin = 0;
      rst = 1'b1; wr = 1'b0; din = '0;
      repeat (3) @(negedge bclk);
      rst = 1'b0;
      @(negedge bclk);
      check($sformatf("c%0d.rst_tx", g), 32'(tx), 32'd1);
      check($sformatf("c%0d.rst_empty", g), 32'(empty), 32'd1);
      check($sformatf("c%0d.rst_busy", g), 32'(busy), 32'd0);

      // Single frame: busy must last exactly one frame length.
      wr = 1'b1; din = DB'(PAT);
      @(negedge bclk);
      wr = 1'b0;
      cyc_cnt = 0; seen = 0;
      for (int i = 0; i < 3 * F && !seen; i++) begin
        @(negedge bclk);
        if (busy) cyc_cnt++;
        if (done) seen = 1;
      end
      check($sformatf("c%0d.busy_len", g), 32'(cyc_cnt), 32'(F));
      check($sformatf("c%0d.done_seen", g), 32'(seen), 32'd1);
      repeat (4) @(negedge bclk);

      // Burst into an idle transmitter: the first word pops right away.
      full_seen = 0;
      for (int i = 0; i < 5; i++) begin
        wr = 1'b1; din = DB'((i == 4) ? 'h66 : 'h11 * (i + 1));
        if (full) full_seen = 1;
        @(negedge bclk);
      end
      wr = 1'b0;
      check($sformatf("c%0d.burst_full", g), 32'(full_seen), 32'(DEPTH < 4));
      for (int i = 0; i < 8 * F && (busy || !empty); i++) @(negedge bclk);
      check($sformatf("c%0d.idle1", g), 32'(busy || !empty), 32'd0);

      // Burst while a frame is on the line: surplus writes overflow.
      wr = 1'b1; din = DB'('h5A);
      @(negedge bclk);
      wr = 1'b0;
      repeat (3) @(negedge bclk);
      n_ovf = 0;
      for (int i = 0; i < 5; i++) begin
        wr = 1'b1; din = DB'((i == 4) ? 'h66 : 'h11 * (i + 1));
        @(negedge bclk);
        if (ovf) n_ovf++;
      end
      wr = 1'b0;
      @(negedge bclk);
      if (ovf) n_ovf++;
      check($sformatf("c%0d.ovf_cnt", g), 32'(n_ovf), 32'(5 - DEPTH));
      n_done = 0; gap = 0;
      for (int i = 0; i < (DEPTH + 3) * F && (busy || !empty); i++) begin
        @(negedge bclk);
        if (done) n_done++;
        if (!busy && !empty) gap = 1;
      end
      check($sformatf("c%0d.b2b_done", g), 32'(n_done), 32'(DEPTH + 1));
      check($sformatf("c%0d.b2b_gap", g), 32'(gap), 32'd0);
      check($sformatf("c%0d.idle2", g), 32'(busy || !empty), 32'd0);

      // Write on the same edge as the stop-end pop with DEPTH-1 words queued.
      wr = 1'b1; din = DB'('h3C);
      @(negedge bclk);
      wr = 1'b0;
      repeat (3) @(negedge bclk);
      for (int i = 0; i < DEPTH - 1; i++) begin
        wr = 1'b1; din = DB'($urandom());
        @(negedge bclk);
      end
      wr = 1'b0;
      for (int i = 0; i < 2 * F && !(active && t == F - 1); i++) @(negedge bclk);
      check($sformatf("c%0d.align", g), 32'(active && t == F - 1), 32'd1);
      wr = 1'b1; din = DB'($urandom());
      @(negedge bclk);
      wr = 1'b0;
      check($sformatf("c%0d.sim_full", g), 32'(full), 32'd0);
      check($sformatf("c%0d.sim_empty", g), 32'(empty), 32'd0);
      n_done = done ? 1 : 0;
      for (int i = 0; i < (DEPTH + 3) * F && (busy || !empty); i++) begin
        @(negedge bclk);
        if (done) n_done++;
      end
      check($sformatf("c%0d.sim_done", g), 32'(n_done), 32'(DEPTH + 1));

      // Reset about 50 cycles into a frame with two words queued.
      for (int i = 0; i < 3; i++) begin
        wr = 1'b1; din = DB'($urandom());
        @(negedge bclk);
      end
      wr = 1'b0;
      repeat (47) @(negedge bclk);
      rst = 1'b1;
      #1;
      check($sformatf("c%0d.rst_async_tx", g), 32'(tx), 32'd1);
      repeat (2) @(negedge bclk);
      rst = 1'b0;
      @(negedge bclk);
      check($sformatf("c%0d.rel_empty", g), 32'(empty), 32'd1);
      check($sformatf("c%0d.rel_busy", g), 32'(busy), 32'd0);
      wr = 1'b1; din = DB'(PAT);
      @(negedge bclk);
      wr = 1'b0;
      n_done = 0;
      for (int i = 0; i < 3 * F && (busy || !empty || n_done == 0); i++) begin
        @(negedge bclk);
        if (done) n_done++;
      end
      check($sformatf("c%0d.post_rst_done", g), 32'(n_done), 32'd1);

      // Random traffic, alternating heavy and light write rates.
      for (int i = 0; i < 4000; i++) begin
        @(negedge bclk);
        if ((i % 1000) < 500) wr = ($urandom_range(0, 3) == 0);
        else                  wr = ($urandom_range(0, 199) == 0);
        din = DB'($urandom());
      end
      @(negedge bclk);
      wr = 1'b0;
      for (int i = 0; i < (DEPTH + 3) * F && (busy || !empty); i++) @(negedge bclk);
      check($sformatf("c%0d.idle_end", g), 32'(busy || !empty), 32'd0);
      fin = 1;
    end
  end

  initial begin : finisher
    bit all_fin;
    all_fin = 0;
    for (int k = 0; k < 90000 && !all_fin; k++) begin
      @(posedge bclk);
      all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin;
    end
    check("watchdog", 32'(all_fin), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
